// File: rtl/compdec_pkg.sv
// Shared constants for the RV32C expander: RV32 base opcodes, quadrant
// codes, compressed funct3 selectors and the register-field helper.
package compdec_pkg;

   // RV32I/F major opcodes produced by the expansion
   localparam logic [6:0] OPCODE_OP       = 7'b0110011;
   localparam logic [6:0] OPCODE_OPIMM    = 7'b0010011;
   localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
   localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
   localparam logic [6:0] OPCODE_LOAD_FP  = 7'b0000111;
   localparam logic [6:0] OPCODE_STORE_FP = 7'b0100111;
   localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
   localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
   localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
   localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

   // instr[1:0]; QUAD_NC marks a full 32-bit instruction
   localparam logic [1:0] QUAD_0  = 2'b00;
   localparam logic [1:0] QUAD_1  = 2'b01;
   localparam logic [1:0] QUAD_2  = 2'b10;
   localparam logic [1:0] QUAD_NC = 2'b11;

   // Quadrant 0 funct3 (instr[15:13])
   localparam logic [2:0] C0_ADDI4SPN = 3'b000;
   localparam logic [2:0] C0_FLD      = 3'b001;
   localparam logic [2:0] C0_LW       = 3'b010;
   localparam logic [2:0] C0_FLW      = 3'b011;
   localparam logic [2:0] C0_RSVD     = 3'b100;
   localparam logic [2:0] C0_FSD      = 3'b101;
   localparam logic [2:0] C0_SW       = 3'b110;
   localparam logic [2:0] C0_FSW      = 3'b111;

   // Quadrant 1 funct3
   localparam logic [2:0] C1_ADDI     = 3'b000;
   localparam logic [2:0] C1_JAL      = 3'b001;
   localparam logic [2:0] C1_LI       = 3'b010;
   localparam logic [2:0] C1_LUI      = 3'b011;
   localparam logic [2:0] C1_MISC_ALU = 3'b100;
   localparam logic [2:0] C1_J        = 3'b101;
   localparam logic [2:0] C1_BEQZ     = 3'b110;
   localparam logic [2:0] C1_BNEZ     = 3'b111;

   // Quadrant 2 funct3
   localparam logic [2:0] C2_SLLI     = 3'b000;
   localparam logic [2:0] C2_FLDSP    = 3'b001;
   localparam logic [2:0] C2_LWSP     = 3'b010;
   localparam logic [2:0] C2_FLWSP    = 3'b011;
   localparam logic [2:0] C2_JR_MV    = 3'b100;
   localparam logic [2:0] C2_FSDSP    = 3'b101;
   localparam logic [2:0] C2_SWSP     = 3'b110;
   localparam logic [2:0] C2_FSWSP    = 3'b111;

   // Result of the field-substitution step before illegal masking
   typedef struct packed {
      logic [31:0] instr;      // substituted 32-bit encoding
      logic        reserved;   // reserved / always-illegal encoding
      logic        fp_op;      // FP load/store, needs the FPU
      logic        no_expand;  // no meaningful substitution exists
   } expand_t;

   // rd'/rs1'/rs2' -> x8..x15 (f8..f15)
   function automatic logic [4:0] creg(input logic [2:0] r);
      return {2'b01, r};
   endfunction

endpackage

// File: rtl/compdec_expand.sv
// Combinational RV32C -> RV32I/F expansion.
// Build option: define COMPDEC_ILLEGAL_CHECK_EN to enable reserved-encoding
// detection; otherwise illegal_instr_o is 0 and fields are substituted as-is.
module compdec_expand
   import compdec_pkg::*;
#(
   parameter bit FPU = 1'b0
) (
   input  logic [31:0] instr_i,
   output logic [31:0] instr_o,
   output logic        is_compressed_o,
   output logic        illegal_instr_o
);

`ifdef COMPDEC_ILLEGAL_CHECK_EN
   localparam bit CheckEn = 1'b1;
`else
   localparam bit CheckEn = 1'b0;
`endif

   logic [15:0] c;
   logic [4:0]  rd;
   logic [4:0]  rs2;
   logic [4:0]  rdp;
   logic [4:0]  rs1p;
   expand_t     ex;
   logic        fp_blocked;
   logic        blocked;

   assign c    = instr_i[15:0];
   assign rd   = c[11:7];
   assign rs2  = c[6:2];
   assign rdp  = creg(c[4:2]);
   assign rs1p = creg(c[9:7]);

   // Field substitution for every compressed encoding, plus reserved flags
   always_comb begin
      ex.instr     = instr_i;
      ex.reserved  = 1'b0;
      ex.fp_op     = 1'b0;
      ex.no_expand = 1'b0;
      case (c[1:0])
         QUAD_0: begin
            case (c[15:13])
               C0_ADDI4SPN: begin
                  ex.instr    = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00,
                                 5'd2, 3'b000, rdp, OPCODE_OPIMM};
                  ex.reserved = (c[12:5] == 8'h00);
               end
               C0_FLD: begin
                  ex.instr    = {4'b0, c[6:5], c[12:10], 3'b000,
                                 rs1p, 3'b011, rdp, OPCODE_LOAD_FP};
                  ex.reserved = 1'b1;
                  ex.fp_op    = 1'b1;
               end
               C0_LW: ex.instr = {5'b0, c[5], c[12:10], c[6], 2'b00,
                                  rs1p, 3'b010, rdp, OPCODE_LOAD};
               C0_FLW: begin
                  ex.instr = {5'b0, c[5], c[12:10], c[6], 2'b00,
                              rs1p, 3'b010, rdp, OPCODE_LOAD_FP};
                  ex.fp_op = 1'b1;
               end
               C0_RSVD: begin
                  ex.reserved  = 1'b1;
                  ex.no_expand = 1'b1;
               end
               C0_FSD: begin
                  ex.instr    = {4'b0, c[6:5], c[12], rdp, rs1p, 3'b011,
                                 c[11:10], 3'b000, OPCODE_STORE_FP};
                  ex.reserved = 1'b1;
                  ex.fp_op    = 1'b1;
               end
               C0_SW: ex.instr = {5'b0, c[5], c[12], rdp, rs1p, 3'b010,
                                  c[11:10], c[6], 2'b00, OPCODE_STORE};
               C0_FSW: begin
                  ex.instr = {5'b0, c[5], c[12], rdp, rs1p, 3'b010,
                              c[11:10], c[6], 2'b00, OPCODE_STORE_FP};
                  ex.fp_op = 1'b1;
               end
            endcase
         end
         QUAD_1: begin
            case (c[15:13])
               C1_ADDI: ex.instr = {{7{c[12]}}, c[6:2], rd, 3'b000, rd, OPCODE_OPIMM};
               C1_JAL, C1_J: ex.instr = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11],
                                         c[5:3], c[12], {8{c[12]}},
                                         4'b0000, ~c[15], OPCODE_JAL};
               C1_LI: ex.instr = {{7{c[12]}}, c[6:2], 5'd0, 3'b000, rd, OPCODE_OPIMM};
               C1_LUI: begin
                  if (rd == 5'd2) begin
                     ex.instr = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000,
                                 5'd2, 3'b000, 5'd2, OPCODE_OPIMM};
                  end else begin
                     ex.instr = {{15{c[12]}}, c[6:2], rd, OPCODE_LUI};
                  end
                  ex.reserved = ({c[12], c[6:2]} == 6'b0);
               end
               C1_MISC_ALU: begin
                  case (c[11:10])
                     2'b00: begin
                        ex.instr    = {7'b0000000, c[6:2], rs1p, 3'b101, rs1p, OPCODE_OPIMM};
                        ex.reserved = c[12];
                     end
                     2'b01: begin
                        ex.instr    = {7'b0100000, c[6:2], rs1p, 3'b101, rs1p, OPCODE_OPIMM};
                        ex.reserved = c[12];
                     end
                     2'b10: ex.instr = {{7{c[12]}}, c[6:2], rs1p, 3'b111, rs1p, OPCODE_OPIMM};
                     2'b11: begin
                        case (c[6:5])
                           2'b00: ex.instr = {7'b0100000, rdp, rs1p, 3'b000, rs1p, OPCODE_OP};
                           2'b01: ex.instr = {7'b0000000, rdp, rs1p, 3'b100, rs1p, OPCODE_OP};
                           2'b10: ex.instr = {7'b0000000, rdp, rs1p, 3'b110, rs1p, OPCODE_OP};
                           2'b11: ex.instr = {7'b0000000, rdp, rs1p, 3'b111, rs1p, OPCODE_OP};
                        endcase
                        ex.reserved = c[12];
                     end
                  endcase
               end
               C1_BEQZ, C1_BNEZ: ex.instr = {c[12], {3{c[12]}}, c[6:5], c[2], 5'd0, rs1p,
                                             2'b00, c[13], c[11:10], c[4:3], c[12],
                                             OPCODE_BRANCH};
            endcase
         end
         QUAD_2: begin
            case (c[15:13])
               C2_SLLI: begin
                  ex.instr    = {7'b0000000, c[6:2], rd, 3'b001, rd, OPCODE_OPIMM};
                  ex.reserved = c[12];
               end
               C2_FLDSP: begin
                  ex.instr    = {3'b0, c[4:2], c[12], c[6:5], 3'b000,
                                 5'd2, 3'b011, rd, OPCODE_LOAD_FP};
                  ex.reserved = 1'b1;
                  ex.fp_op    = 1'b1;
               end
               C2_LWSP: begin
                  ex.instr    = {4'b0, c[3:2], c[12], c[6:4], 2'b00,
                                 5'd2, 3'b010, rd, OPCODE_LOAD};
                  ex.reserved = (rd == 5'd0);
               end
               C2_FLWSP: begin
                  ex.instr = {4'b0, c[3:2], c[12], c[6:4], 2'b00,
                              5'd2, 3'b010, rd, OPCODE_LOAD_FP};
                  ex.fp_op = 1'b1;
               end
               C2_JR_MV: begin
                  if (!c[12]) begin
                     if (rs2 == 5'd0) begin
                        ex.instr    = {12'b0, rd, 3'b000, 5'd0, OPCODE_JALR};
                        ex.reserved = (rd == 5'd0);
                     end else begin
                        ex.instr = {7'b0000000, rs2, 5'd0, 3'b000, rd, OPCODE_OP};
                     end
                  end else if (rs2 == 5'd0) begin
                     if (rd == 5'd0) begin
                        ex.instr = {12'h001, 13'b0, OPCODE_SYSTEM};
                     end else begin
                        ex.instr = {12'b0, rd, 3'b000, 5'd1, OPCODE_JALR};
                     end
                  end else begin
                     ex.instr = {7'b0000000, rs2, rd, 3'b000, rd, OPCODE_OP};
                  end
               end
               C2_FSDSP: begin
                  ex.instr    = {3'b0, c[9:7], c[12], rs2, 5'd2, 3'b011,
                                 c[11:10], 3'b000, OPCODE_STORE_FP};
                  ex.reserved = 1'b1;
                  ex.fp_op    = 1'b1;
               end
               C2_SWSP: ex.instr = {4'b0, c[8:7], c[12], rs2, 5'd2, 3'b010,
                                    c[11:9], 2'b00, OPCODE_STORE};
               C2_FSWSP: begin
                  ex.instr = {4'b0, c[8:7], c[12], rs2, 5'd2, 3'b010,
                              c[11:9], 2'b00, OPCODE_STORE_FP};
                  ex.fp_op = 1'b1;
               end
            endcase
         end
         default: ex.instr = instr_i;
      endcase
   end

   // FP loads/stores without an FPU are never expanded; reserved encodings
   // pass through untouched only when the check is built in.
   assign fp_blocked      = ex.fp_op & ~FPU;
   assign blocked         = fp_blocked | ex.no_expand | (CheckEn & ex.reserved);
   assign instr_o         = blocked ? instr_i : ex.instr;
   assign is_compressed_o = (c[1:0] != QUAD_NC);
   assign illegal_instr_o = CheckEn & (ex.reserved | fp_blocked);

endmodule

// File: rtl/compressed_decoder.sv
// RV32C instruction expander with one registered output stage.
// Build option: COMPDEC_ILLEGAL_CHECK_EN enables illegal-encoding detection.
module compressed_decoder
   import compdec_pkg::*;
#(
   parameter bit FPU = 1'b0
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        valid_i,
   input  logic [31:0] instr_i,
   output logic        valid_o,
   output logic [31:0] instr_o,
   output logic        is_compressed_o,
   output logic        illegal_instr_o
);

   logic [31:0] exp_instr;
   logic        exp_compressed;
   logic        exp_illegal;

   compdec_expand #(
      .FPU (FPU)
   ) u_expand (
      .instr_i         (instr_i),
      .instr_o         (exp_instr),
      .is_compressed_o (exp_compressed),
      .illegal_instr_o (exp_illegal)
   );

   // Output stage: valid follows every cycle, data loads only on valid_i
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_o         <= 1'b0;
         instr_o         <= '0;
         is_compressed_o <= 1'b0;
         illegal_instr_o <= 1'b0;
      end else begin
         valid_o <= valid_i;
         if (valid_i) begin
            instr_o         <= exp_instr;
            is_compressed_o <= exp_compressed;
            illegal_instr_o <= exp_illegal;
         end
      end
   end

endmodule

// File: tb/tb_compressed_decoder.sv
// Directed-vector bench for compressed_decoder; one instance per FPU setting.
module tb_compressed_decoder;

`ifdef COMPDEC_ILLEGAL_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        valid;
   logic [31:0] instr;
   logic        valid0, comp0, ill0;
   logic [31:0] out0;
   logic        valid1, comp1, ill1;
   logic [31:0] out1;

   int total;
   int passed;

   typedef struct {
      string       name;
      logic [31:0] instr;
      logic [31:0] exp0;
      logic        ill0;
      logic [31:0] exp1;
      logic        ill1;
      logic        comp;
   } vec_t;

   vec_t vecs[18];

   compressed_decoder #(.FPU(1'b0)) dut0 (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .valid_i         (valid),
      .instr_i         (instr),
      .valid_o         (valid0),
      .instr_o         (out0),
      .is_compressed_o (comp0),
      .illegal_instr_o (ill0)
   );

   compressed_decoder #(.FPU(1'b1)) dut1 (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .valid_i         (valid),
      .instr_i         (instr),
      .valid_o         (valid1),
      .instr_o         (out1),
      .is_compressed_o (comp1),
      .illegal_instr_o (ill1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " valid0"}, {31'b0, valid0}, 32'h0);
      check({tag, " instr0"}, out0, 32'h0);
      check({tag, " comp0"},  {31'b0, comp0},  32'h0);
      check({tag, " ill0"},   {31'b0, ill0},   32'h0);
      check({tag, " valid1"}, {31'b0, valid1}, 32'h0);
      check({tag, " instr1"}, out1, 32'h0);
      check({tag, " ill1"},   {31'b0, ill1},   32'h0);
   endtask

   initial begin
      total  = 0;
      passed = 0;
      rst_n  = 1'b0;
      valid  = 1'b0;
      instr  = 32'h0;

      vecs[0]  = '{"nop32",    32'h0000_0013, 32'h0000_0013, 1'b0, 32'h0000_0013, 1'b0, 1'b0};
      vecs[1]  = '{"pass32",   32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0};
      vecs[2]  = '{"c.addi",   32'h1234_0085, 32'h0010_8093, 1'b0, 32'h0010_8093, 1'b0, 1'b1};
      vecs[3]  = '{"c.nop",    32'h0000_0001, 32'h0000_0013, 1'b0, 32'h0000_0013, 1'b0, 1'b1};
      vecs[4]  = '{"c.lw",     32'h0000_4080, 32'h0004_A403, 1'b0, 32'h0004_A403, 1'b0, 1'b1};
      vecs[5]  = '{"c.mv",     32'h0000_808A, 32'h0020_00B3, 1'b0, 32'h0020_00B3, 1'b0, 1'b1};
      vecs[6]  = '{"zero",     32'h0000_0000,
                   CHK ? 32'h0000_0000 : 32'h0001_0413, CHK,
                   CHK ? 32'h0000_0000 : 32'h0001_0413, CHK, 1'b1};
      vecs[7]  = '{"c.flw",    32'h0000_6080, 32'h0000_6080, CHK, 32'h0004_A407, 1'b0, 1'b1};
      vecs[8]  = '{"c.li",     32'h0000_557D, 32'hFFF0_0513, 1'b0, 32'hFFF0_0513, 1'b0, 1'b1};
      vecs[9]  = '{"c.beqz",   32'h0000_C001, 32'h0004_0063, 1'b0, 32'h0004_0063, 1'b0, 1'b1};
      vecs[10] = '{"c.swsp",   32'h0000_C206, 32'h0011_2223, 1'b0, 32'h0011_2223, 1'b0, 1'b1};
      vecs[11] = '{"c.ebreak", 32'h0000_9002, 32'h0010_0073, 1'b0, 32'h0010_0073, 1'b0, 1'b1};
      vecs[12] = '{"c.jr",     32'h0000_8082, 32'h0000_8067, 1'b0, 32'h0000_8067, 1'b0, 1'b1};
      vecs[13] = '{"c.addi16sp0", 32'h0000_6101,
                   CHK ? 32'h0000_6101 : 32'h0001_0113, CHK,
                   CHK ? 32'h0000_6101 : 32'h0001_0113, CHK, 1'b1};
      vecs[14] = '{"c.j",      32'h0000_BFFD, 32'hFFFF_F06F, 1'b0, 32'hFFFF_F06F, 1'b0, 1'b1};
      vecs[15] = '{"c.sub",    32'h0000_8C05, 32'h4094_0433, 1'b0, 32'h4094_0433, 1'b0, 1'b1};
      vecs[16] = '{"c.fswsp",  32'h0000_E006, 32'h0000_E006, CHK, 32'h0011_2027, 1'b0, 1'b1};
      vecs[17] = '{"c.fld",    32'h0000_2080, 32'h0000_2080, CHK,
                   CHK ? 32'h0000_2080 : 32'h0004_B407, CHK, 1'b1};

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // table-driven vectors
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         valid = 1'b1;
         instr = vecs[i].instr;
         @(posedge clk);
         #1;
         check({vecs[i].name, " valid0"}, {31'b0, valid0}, 32'h1);
         check({vecs[i].name, " instr0"}, out0, vecs[i].exp0);
         check({vecs[i].name, " ill0"},   {31'b0, ill0},  {31'b0, vecs[i].ill0});
         check({vecs[i].name, " comp0"},  {31'b0, comp0}, {31'b0, vecs[i].comp});
         check({vecs[i].name, " instr1"}, out1, vecs[i].exp1);
         check({vecs[i].name, " ill1"},   {31'b0, ill1},  {31'b0, vecs[i].ill1});
         check({vecs[i].name, " comp1"},  {31'b0, comp1}, {31'b0, vecs[i].comp});
      end

      // hold: data keeps last decode while valid_i is low
      @(negedge clk);
      valid = 1'b1;
      instr = 32'h0000_808A;
      @(posedge clk);
      #1;
      check("hold load", out0, 32'h0020_00B3);
      @(negedge clk);
      valid = 1'b0;
      instr = 32'h0000_4080;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         check("hold valid0", {31'b0, valid0}, 32'h0);
         check("hold instr0", out0, 32'h0020_00B3);
         check("hold comp0",  {31'b0, comp0}, 32'h1);
         check("hold instr1", out1, 32'h0020_00B3);
      end

      // asynchronous reset while valid_o is high
      @(negedge clk);
      valid = 1'b1;
      instr = 32'h0000_0085;
      @(posedge clk);
      #1;
      check("pre-rst valid0", {31'b0, valid0}, 32'h1);
      check("pre-rst instr0", out0, 32'h0010_8093);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("async rst");

      // first valid after release decodes normally
      @(negedge clk);
      instr = 32'h0000_4080;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post-rst valid0", {31'b0, valid0}, 32'h1);
      check("post-rst instr0", out0, 32'h0004_A403);
      check("post-rst comp0",  {31'b0, comp0}, 32'h1);
      check("post-rst instr1", out1, 32'h0004_A403);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/compressed_decoder.md
Name: compressed_decoder

Overview:
- RV32C instruction expander with one registered output stage.
- Takes a 32-bit fetch word. If bits[1:0] != 2'b11, expands the low 16 bits to the equivalent 32-bit RV32I/F encoding; otherwise passes the word through unchanged.
- Sits between instruction fetch/trace capture and the decoder/tracer.
- Outputs are valid 1 cycle after input.

Parameters:
- FPU, 0, 1 enables C.FLW/C.FSW/C.FLWSP/C.FSWSP expansion; 0 makes them illegal.

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- valid_i  in  1  instr_i is valid this cycle
- instr_i  in  32  fetched instruction; only [15:0] used when compressed
- valid_o  out  1  registered copy of valid_i
- instr_o  out  32  expanded (or passed-through) instruction
- is_compressed_o  out  1  input had bits[1:0] != 2'b11
- illegal_instr_o  out  1  compressed encoding reserved or unsupported

Behaviour:
- Reset (async assert, sync deassert on clk_i): valid_o=0, instr_o=0, is_compressed_o=0, illegal_instr_o=0.
- valid_o <= valid_i every cycle.
- Data outputs load only when valid_i=1 and hold otherwise.
- Latency: exactly 1 cycle; no backpressure.
- Decode logic is a pure combinational function; the output registers capture its result.
- Uncompressed input (bits[1:0]=11): instr_o=instr_i, is_compressed_o=0, illegal_instr_o=0.
- Compressed illegal case: instr_o=instr_i (unchanged), illegal_instr_o=1.
- Register mapping: rd'/rs1'/rs2' 3-bit fields map to x8..x15 (f8..f15 for FP). All immediates are sign- or zero-extended per the RVC spec.
- Q0 (op=00):
  - 000 C.ADDI4SPN -> ADDI rd',x2,nzuimm; nzuimm=0 (incl. 0x0000) illegal.
  - 001 C.FLD and 101 C.FSD: always illegal (RV32 F only).
  - 010 C.LW -> LW; 110 C.SW -> SW.
  - 011 C.FLW / 111 C.FSW -> FLW/FSW when FPU=1, else illegal.
  - 100 reserved: illegal.
- Q1 (op=01):
  - 000 C.ADDI/C.NOP -> ADDI rd,rd,imm.
  - 001 C.JAL -> JAL x1.
  - 010 C.LI -> ADDI rd,x0,imm.
  - 011 with rd=2: C.ADDI16SP, illegal if imm=0.
  - 011 otherwise: C.LUI, illegal if imm=0.
  - 100: C.SRLI/C.SRAI, illegal if instr[12]=1; C.ANDI; C.SUB/XOR/OR/AND; instr[12]=1 in the register-register group is illegal.
  - 101 C.J -> JAL x0.
  - 110 C.BEQZ / 111 C.BNEZ -> BEQ/BNE rs1',x0.
- Q2 (op=10):
  - 000 C.SLLI, illegal if instr[12]=1.
  - 001 C.FLDSP: illegal.
  - 010 C.LWSP, illegal if rd=0.
  - 011 C.FLWSP when FPU=1, else illegal.
  - 100 with instr[12]=0: C.JR (rs1=0 illegal) or C.MV -> ADD rd,x0,rs2.
  - 100 with instr[12]=1: C.EBREAK (rd=rs2=0), C.JALR (rs2=0) -> JALR x1, or C.ADD.
  - 101 C.FSDSP: illegal.
  - 110 C.SWSP.
  - 111 C.FSWSP when FPU=1, else illegal.
- HINT encodings (e.g. C.ADDI with rd=0, C.LI with rd=0) are legal and expanded literally.
- Reset asserted mid-stream clears all outputs immediately; the first valid_i after deassertion is handled normally.

Optional Feature:
- Macro COMPDEC_ILLEGAL_CHECK_EN.
- Defined: illegal detection as specified above.
- Undefined: illegal_instr_o is tied 0 and every compressed encoding expands by field substitution with no reserved-value checks. FP loads/stores still follow FPU.

Decomposition:
- Shared package compdec_pkg holds opcode constants (OPCODE_OP, OPCODE_OPIMM, OPCODE_LOAD, OPCODE_STORE, OPCODE_LOAD_FP, OPCODE_STORE_FP, OPCODE_LUI, OPCODE_JAL, OPCODE_JALR, OPCODE_BRANCH, OPCODE_SYSTEM) and the quadrant/funct3 localparams.
- One natural sub-module: compdec_expand (purely combinational expansion, FPU parameter).
- The top module adds the reset and valid registers.

Test Plan:
- 0x00000013 with valid_i=1 -> next cycle valid_o=1, instr_o=0x00000013, is_compressed_o=0, illegal_instr_o=0.
- 0x0085 (C.ADDI x1,1) -> instr_o=0x00108093, is_compressed_o=1; 0x0001 (C.NOP) -> 0x00000013.
- 0x4080 (C.LW x8,0(x9)) -> 0x0004A403; 0x808A (C.MV x1,x2) -> 0x002000B3.
- 0x0000 -> illegal_instr_o=1, instr_o=0x00000000.
- 0x6080 (C.FLW f8,0(x9)): FPU=0 -> illegal_instr_o=1; FPU=1 -> instr_o=0x0004A407, illegal_instr_o=0.
- Assert rst_ni=0 while valid_o=1 -> all outputs 0 without waiting for a clock edge. Hold valid_i=0 for 3 cycles after a decode -> instr_o holds its value, valid_o=0.
